// File: rtl/sc_pkg.sv
// Shared definitions for the instruction-fetch stage: word width,
// pcsource encodings and the fetch FSM state type.
package sc_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sc_ifetch_if.sv
// Instruction-memory request/acknowledge bus. The fetch stage is the
// master; the memory model or memory controller is the slave.
interface sc_ifetch_if;
    import sc_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] inst_in;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  inst_in
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output inst_in
    );

endinterface

// File: rtl/sc_next_pc.sv
// Combinational next-PC target computation. Produces pc+4, the target
// selected by pcsource, and a flag for a jr through a non-word-aligned
// register value. The jr target always has its low two bits cleared; the
// caller decides whether a misaligned jr traps instead.
module sc_next_pc
    import sc_pkg::*;
(
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] inst_i,
    input  logic [WORD_W-1:0] ra_i,
    input  logic [1:0]        pcsource_i,
    output logic [WORD_W-1:0] pc4_o,
    output logic [WORD_W-1:0] next_pc_o,
    output logic              misalign_cond_o
);

    logic [WORD_W-1:0] br_off;
    logic [5:0]        unused_opcode;

    assign pc4_o           = pc_i + 32'd4;
    // Branch offset is a signed word count: sign-extend and scale by 4.
    assign br_off          = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
    assign misalign_cond_o = (pcsource_i == PCSRC_JR) && (ra_i[1:0] != 2'b00);
    // The opcode field does not participate in target computation.
    assign unused_opcode   = inst_i[31:26];

    // Target mux selected by the control unit's pcsource
    always_comb begin
        next_pc_o = pc4_o;
        case (pcsource_i)
            PCSRC_BR: next_pc_o = pc4_o + br_off;
            PCSRC_JR: next_pc_o = {ra_i[31:2], 2'b00};
            PCSRC_J:  next_pc_o = {pc4_o[31:28], inst_i[25:0], 2'b00};
            default:  next_pc_o = pc4_o;
        endcase
    end

endmodule

// File: rtl/sc_ifetch.sv
// Instruction-fetch / PC-sequencing stage feeding the single-cycle
// control unit. Two-state FSM: FETCH requests the word at pc and waits
// for ack; EXEC holds the word for decode until a non-stalled commit,
// which advances pc and the retired-instruction counter.
// Optional build macro SC_IFETCH_MISALIGN_TRAP_EN: a committed jr whose
// register value is not word aligned redirects to TRAP_PC and pulses
// misalign for one cycle. Without it the low address bits are dropped.
module sc_ifetch
    import sc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic               clock,
    input  logic               resetn,
    sc_ifetch_if.master        imem,
    input  logic               stall,
    input  logic [1:0]         pcsource,
    input  logic [WORD_W-1:0]  ra,
    output logic [WORD_W-1:0]  inst,
    output logic               inst_valid,
    output logic [WORD_W-1:0]  pc,
    output logic [WORD_W-1:0]  pc4,
    output logic [WORD_W-1:0]  retired,
    output logic               misalign
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] retired_q, retired_d;
    logic [WORD_W-1:0] next_pc;
    logic              misalign_cond;
    logic              req;

`ifdef SC_IFETCH_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    sc_next_pc u_next_pc (
        .pc_i            (pc_q),
        .inst_i          (inst_q),
        .ra_i            (ra),
        .pcsource_i      (pcsource),
        .pc4_o           (pc4),
        .next_pc_o       (next_pc),
        .misalign_cond_o (misalign_cond)
    );

    // Next-state logic, register next values and the fetch request strobe
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        req       = 1'b0;
`ifdef SC_IFETCH_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                // Request is suppressed while reset is asserted so an
                // abandoned fetch is never re-issued mid-reset.
                req = resetn;
                if (imem.imem_ack) begin
                    inst_d  = imem.inst_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // pcsource and ra only matter on this commit edge.
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
`ifdef SC_IFETCH_MISALIGN_TRAP_EN
                    if (misalign_cond) begin
                        pc_d       = TRAP_PC;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC, held instruction and retire counter; reset wins over stall
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
`ifdef SC_IFETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
`ifdef SC_IFETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = (state_q == EXEC);
    assign pc             = pc_q;
    assign retired        = retired_q;

`ifdef SC_IFETCH_MISALIGN_TRAP_EN
    assign misalign = misalign_q;
`else
    logic unused_trap;
    assign misalign    = 1'b0;
    assign unused_trap = ^{misalign_cond, TRAP_PC};
`endif

endmodule

// File: tb/tb_sc_ifetch.sv
// Testbench for sc_ifetch: directed scenarios followed by randomized
// instruction streams. A driver plays instruction memory and the control
// unit and pushes expectations from a reference model of the PC rules;
// a monitor on the falling edge pops and compares them.
module tb_sc_ifetch;

    localparam logic [31:0] RESET_PC_C = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_C  = 32'h0000_0080;
`ifdef SC_IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ret;
    } fexp_t;

    logic        clock;
    logic        resetn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] ra;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] retired;
    logic        misalign;

    sc_ifetch_if imem_if ();

    sc_ifetch #(
        .RESET_PC (RESET_PC_C),
        .TRAP_PC  (TRAP_PC_C)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .imem       (imem_if.master),
        .stall      (stall),
        .pcsource   (pcsource),
        .ra         (ra),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .retired    (retired),
        .misalign   (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    fexp_t       exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic        exp_mis_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_ret;
    bit          mon_en = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Architectural next-PC rule, written as plain word arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pcv, input logic [31:0] word,
                                               input logic [31:0] rav, input logic [1:0] ps,
                                               output logic mis);
        logic [31:0] seq;
        seq = pcv + 32'd4;
        mis = 1'b0;
        case (ps)
            2'd0: return seq;
            2'd1: return seq + 32'($signed(word[15:0])) * 32'd4;
            2'd2: begin
                if (TRAP_EN && (rav % 32'd4) != 32'd0) begin
                    mis = 1'b1;
                    return TRAP_PC_C;
                end
                return rav - (rav % 32'd4);
            end
            default: return (seq / 32'h1000_0000) * 32'h1000_0000 + (word % 32'h0400_0000) * 32'd4;
        endcase
    endfunction

    fexp_t       cur;
    logic [31:0] cur_inst;
    logic        prev_valid;
    logic        em;

    // Monitor: compare DUT outputs against queued expectations
    always @(negedge clock) begin
        if (mon_en) begin
            chk1("imem_req", imem_if.imem_req, resetn && !inst_valid);
            if (imem_if.imem_req) begin
                if (exp_addr_q.size() == 0) begin
                    chk1("fetch_expected", 1'b0, 1'b1);
                end else begin
                    chk32("imem_addr", imem_if.imem_addr, exp_addr_q[0].addr);
                    if (imem_if.imem_ack) begin
                        cur = exp_addr_q.pop_front();
                        chk32("retired_at_fetch", retired, cur.ret);
                        chk32("pc4", pc4, cur.addr + 32'd4);
                    end
                end
            end
            if (inst_valid && !prev_valid) begin
                if (exp_inst_q.size() == 0) chk1("inst_expected", 1'b0, 1'b1);
                else cur_inst = exp_inst_q.pop_front();
            end
            if (inst_valid) begin
                chk32("inst_hold", inst, cur_inst);
                chk32("pc_hold", pc, cur.addr);
                chk32("retired_hold", retired, cur.ret);
            end
            em = 1'b0;
            if (prev_valid && !inst_valid) begin
                if (exp_mis_q.size() == 0) chk1("commit_expected", 1'b0, 1'b1);
                else em = exp_mis_q.pop_front();
            end
            chk1("misalign", misalign, em);
            prev_valid = inst_valid;
        end
    end

    task automatic do_instr(input logic [31:0] word, input int waits, input int stalls,
                            input logic [1:0] ps, input logic [31:0] rav);
        int          k;
        logic        mis;
        logic [31:0] nxt;
        imem_if.imem_ack = 1'b0;
        k = 0;
        while (!imem_if.imem_req && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        chk1("req_timeout", imem_if.imem_req, 1'b1);
        repeat (waits) begin
            pcsource = 2'($urandom);
            ra       = $urandom;
            @(posedge clock); #1;
        end
        imem_if.imem_ack = 1'b1;
        imem_if.inst_in  = word;
        exp_inst_q.push_back(word);
        @(posedge clock); #1;
        // Acks seen during EXEC carry junk and must be ignored.
        imem_if.imem_ack = 1'($urandom);
        imem_if.inst_in  = $urandom;
        repeat (stalls) begin
            stall    = 1'b1;
            pcsource = 2'($urandom);
            ra       = $urandom;
            @(posedge clock); #1;
        end
        stall    = 1'b0;
        pcsource = ps;
        ra       = rav;
        nxt      = model_next(model_pc, word, rav, ps, mis);
        @(posedge clock); #1;
        model_pc  = nxt;
        model_ret = model_ret + 32'd1;
        exp_addr_q.push_back('{addr: nxt, ret: model_ret});
        exp_mis_q.push_back(mis);
        imem_if.imem_ack = 1'b0;
        pcsource = 2'($urandom);
        ra       = $urandom;
    endtask

    task automatic restart_model();
        exp_addr_q.delete();
        exp_inst_q.delete();
        exp_mis_q.delete();
        model_pc  = RESET_PC_C;
        model_ret = 32'd0;
        exp_addr_q.push_back('{addr: RESET_PC_C, ret: 32'd0});
        prev_valid = 1'b0;
    endtask

    initial begin
        resetn           = 1'b0;
        stall            = 1'b0;
        pcsource         = 2'b00;
        ra               = 32'd0;
        imem_if.imem_ack = 1'b1;
        imem_if.inst_in  = 32'hDEAD_BEEF;
        prev_valid       = 1'b0;
        cur              = '0;
        cur_inst         = '0;
        repeat (2) @(posedge clock);
        #1;
        chk32("reset_pc", pc, RESET_PC_C);
        chk32("reset_inst", inst, 32'd0);
        chk1("reset_inst_valid", inst_valid, 1'b0);
        chk32("reset_retired", retired, 32'd0);
        chk1("reset_misalign", misalign, 1'b0);
        chk1("reset_req", imem_if.imem_req, 1'b0);
        restart_model();
        imem_if.imem_ack = 1'b0;
        resetn = 1'b1;
        mon_en = 1'b1;

        // Sequential fetch 0x0, 0x4, 0x8, 0xC then to 0x10
        for (int i = 0; i < 4; i++) do_instr($urandom, 0, 0, 2'b00, $urandom);
        chk32("pc_seq_0x10", model_pc, 32'h10);
        // Branch back by two words
        do_instr(32'h1000_FFFE, 0, 0, 2'b01, 32'd0);
        // jr to 0x3000_0000, j within that region, jr back to 0x2000
        do_instr($urandom, 0, 0, 2'b10, 32'h3000_0000);
        do_instr(32'h0800_0040, 0, 0, 2'b11, 32'd0);
        do_instr($urandom, 0, 0, 2'b10, 32'h0000_2000);
        // Wait states and stall
        do_instr($urandom, 3, 4, 2'b00, 32'd0);
        // Reset abandoned mid-fetch at pc 0x40, with a late ack during reset
        do_instr($urandom, 1, 0, 2'b10, 32'h0000_0040);
        repeat (2) begin @(posedge clock); #1; end
        chk32("fetch_pc_0x40", pc, 32'h40);
        resetn           = 1'b0;
        imem_if.imem_ack = 1'b1;
        imem_if.inst_in  = 32'hBAD0_BAD0;
        restart_model();
        @(posedge clock); #1;
        resetn           = 1'b1;
        imem_if.imem_ack = 1'b0;
        chk32("midreset_pc", pc, RESET_PC_C);
        chk1("midreset_inst_valid", inst_valid, 1'b0);
        chk32("midreset_inst", inst, 32'd0);
        chk32("midreset_retired", retired, 32'd0);
        // Wrap-around of pc+4
        do_instr($urandom, 0, 0, 2'b10, 32'hFFFF_FFFC);
        do_instr($urandom, 0, 1, 2'b00, 32'd0);
        // Misaligned jr
        do_instr($urandom, 0, 0, 2'b10, 32'h0000_2002);
        chk32("misaligned_jr_target", model_pc, TRAP_EN ? TRAP_PC_C : 32'h0000_2000);
        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     2'($urandom), $urandom);
        end
        repeat (3) begin @(posedge clock); #1; end
        chk32("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);
        chk32("mis_queue_drained", 32'(exp_mis_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
